axi_stream_dw_upsizer_flex: RTL and testbench
=============================================

AXI_STREAM_DW_UPSIZER_FLEX -- requirements
Module: axi_stream_dw_upsizer_flex

Interface
REQ-001 SHALL have parameter DataWidthIn, default 8: input tdata width in bits, a multiple of 8.
REQ-002 SHALL have parameter DataWidthOut, default 32: output tdata width, an integer multiple N=DataWidthOut/DataWidthIn with N>=2.
REQ-003 SHALL have parameter IdWidth, default 0: tid width.
REQ-004 SHALL have parameter DestWidth, default 0: tdest width.
REQ-005 SHALL have parameter UserWidth, default 0: per-input-beat tuser width; output tuser is UserWidth*N wide.
REQ-006 SHALL have parameter FlushOnRouteChange, default 1: when set, a tid or tdest change terminates the partial output word.
REQ-007 SHALL have type parameters axi_stream_in_req_t, axi_stream_in_rsp_t, axi_stream_out_req_t and axi_stream_out_rsp_t: the port structs.
REQ-008 SHALL have port clk_i, input, 1 bit: the single clock; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port in_req_i, input, axi_stream_in_req_t: narrow tvalid plus t.{data,strb,keep,last,id,dest,user}.
REQ-011 SHALL have port in_rsp_o, output, axi_stream_in_rsp_t: narrow tready.
REQ-012 SHALL have port out_req_o, output, axi_stream_out_req_t: wide tvalid plus payload.
REQ-013 SHALL have port out_rsp_i, input, axi_stream_out_rsp_t: wide tready.

Function
REQ-014 SHALL pack input beat k of a word (k=0..N-1) into lane k: data bits [k*DataWidthIn +: DataWidthIn], with strb, keep and user at the matching lane offsets; first beat goes in the LSBs.
REQ-015 SHALL hold one output buffer plus a lane counter of $clog2(N) bits and an output-valid flag; FSM states: Fill (flag 0) and Full (flag 1).
REQ-016 SHALL, in Fill, drive in tready=1; each accepted beat writes its lane, latches last/id/dest, and increments the counter.
REQ-017 SHALL go from Fill to Full when the accepted beat fills lane N-1 or carries tlast=1.
REQ-018 SHALL zero data, strb, keep and user in every lane above the last written lane of a tlast-terminated word; no dead padding cycles.
REQ-019 SHALL, when FlushOnRouteChange=1, counter>0, and a valid input beat's id/dest differs from the latched values, go to Full without accepting that beat (in tready=0 that cycle); out last=0 and the unfilled lanes are zeroed.
REQ-020 SHALL, in Full, drive out tvalid=1 with a stable payload until out tready=1.
REQ-021 SHALL, in Full, drive in tready equal to out tready, so that a wide handshake and a narrow beat in the same cycle send the word, write the new beat into lane 0 of a cleared buffer, and set the counter to 1; sustained throughput is one narrow beat per cycle.
REQ-022 SHALL treat N=... a beat arriving in Full with tlast=1 and N lanes as a complete one-beat word: Full again next cycle.
REQ-023 SHALL have a minimum latency from the last contributing narrow handshake to out tvalid of 1 cycle.
REQ-024 SHALL never drop, duplicate or reorder beats, and in tready SHALL not depend on in tvalid.

Reset
REQ-025 SHALL, on rst_ni=0, immediately force state Fill, counter 0, out tvalid 0, and the buffer, last, id and dest to 0.
REQ-026 SHALL discard a partial or pending word when reset is asserted mid-operation; the first beat after release lands in lane 0.
REQ-027 SHALL drive in tready=1 combinationally from the cycle after reset deassertion.

Structure
REQ-028 SHALL put the Fill/Full state enum in a shared package, axi_stream_dw_pkg, for reuse by the downsizer.
REQ-029 SHALL implement lane write and clear in a sub-module, axi_stream_dw_lane_buf, parameterised by lane width and N.
REQ-030 SHALL check the parameters with simulation-only elaboration assertions: DataWidthIn%8==0, DataWidthOut%DataWidthIn==0, N>=2.

Verification
REQ-031 SHALL cover full word: N=4, bytes 0x11,0x22,0x33,0x44 (last on 0x44), out tready=1 -> data=0x44332211, keep=0xF, last=1, one cycle after 0x44.
REQ-032 SHALL cover short packet: 0xAA,0xBB with last on 0xBB -> data=0x0000BBAA, keep=0x3, strb=0x3, last=1.
REQ-033 SHALL cover backpressure: out tready=0 for 5 cycles while Full -> payload stable, in tready=0, no input accepted; release -> next beat goes to lane 0 in the same cycle.
REQ-034 SHALL cover route change: id=1 beats 0x01,0x02, then id=2 beat 0x03 -> word 0x00000201 with keep=0x3, last=0, id=1; then 0x03 starts a new word with id=2.
REQ-035 SHALL cover streaming: 64 random beats, both tvalid and tready=1 -> 16 output words, one per 4 cycles, matching the scoreboard.
REQ-036 SHALL cover reset mid-word: reset after 2 beats -> out tvalid=0 immediately; next word packs from lane 0.

Source files
------------

// File: rtl/axi_stream_dw_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : axi_stream_dw_pkg                                             |
// | Brief  : Shared types for the AXI-Stream data-width converters: the    |
// |          Fill/Full state enum, default 8->32 port structs and a helper |
// |          that computes the lane ratio.                                 |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package axi_stream_dw_pkg;

  // Word-assembly state; the encoding equals the output-valid flag.
  typedef enum logic [0:0] {
    DW_FILL = 1'b0,
    DW_FULL = 1'b1
  } dw_state_e;

  // Default payload geometry: 8-bit narrow side, 4 lanes, 1-bit side bands.
  localparam int unsigned C_DEF_W_IN  = 8;
  localparam int unsigned C_DEF_LANES = 4;

  typedef struct packed {
    logic [C_DEF_W_IN-1:0]    data;
    logic [C_DEF_W_IN/8-1:0]  strb;
    logic [C_DEF_W_IN/8-1:0]  keep;
    logic                     last;
    logic [0:0]               id;
    logic [0:0]               dest;
    logic [0:0]               user;
  } axis_narrow_t;

  typedef struct packed {
    axis_narrow_t t;
    logic         tvalid;
  } axis_narrow_req_t;

  typedef struct packed {
    logic [C_DEF_LANES*C_DEF_W_IN-1:0]   data;
    logic [C_DEF_LANES*C_DEF_W_IN/8-1:0] strb;
    logic [C_DEF_LANES*C_DEF_W_IN/8-1:0] keep;
    logic                                last;
    logic [0:0]                          id;
    logic [0:0]                          dest;
    logic [C_DEF_LANES-1:0]              user;
  } axis_wide_t;

  typedef struct packed {
    axis_wide_t t;
    logic       tvalid;
  } axis_wide_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

  // Number of narrow lanes in one wide word.
  function automatic int unsigned dw_ratio(input int unsigned w_narrow, input int unsigned w_wide);
    return w_wide / w_narrow;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_dw_lane_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : axi_stream_dw_lane_buf                                        |
// | Brief  : N-lane word buffer. One lane is written per beat; a clear     |
// |          wipes every lane except one written in the same cycle.        |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module axi_stream_dw_lane_buf #(
  parameter int unsigned LaneWidth = 10,
  parameter int unsigned NumLanes  = 4,
  localparam int unsigned C_IDX_W  = $clog2(NumLanes)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          wr_en_i,
  input  logic [C_IDX_W-1:0]            wr_lane_i,
  input  logic [LaneWidth-1:0]          wr_data_i,
  output logic [NumLanes*LaneWidth-1:0] buf_o
);

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    logic [LaneWidth-1:0] r_lane;

    // Write beats win over the clear so a new word can start in lane 0 while the old one leaves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_lane <= '0;
      end else if (wr_en_i && (wr_lane_i == C_IDX_W'(k))) begin
        r_lane <= wr_data_i;
      end else if (clear_i) begin
        r_lane <= '0;
      end
    end

    assign buf_o[k*LaneWidth +: LaneWidth] = r_lane;
  end

endmodule
`default_nettype wire

// File: rtl/axi_stream_dw_upsizer_flex.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : axi_stream_dw_upsizer_flex                                    |
// | Brief  : AXI-Stream width upsizer. Packs N narrow beats (first beat in |
// |          the LSBs) into one wide word; tlast or a route change closes  |
// |          a short word with its unused lanes zeroed.                    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module axi_stream_dw_upsizer_flex
  import axi_stream_dw_pkg::*;
#(
  parameter int unsigned DataWidthIn        = 8,
  parameter int unsigned DataWidthOut       = 32,
  parameter int unsigned IdWidth            = 0,
  parameter int unsigned DestWidth          = 0,
  parameter int unsigned UserWidth          = 0,
  parameter bit          FlushOnRouteChange = 1'b1,
  parameter type axi_stream_in_req_t  = axis_narrow_req_t,
  parameter type axi_stream_in_rsp_t  = axis_rsp_t,
  parameter type axi_stream_out_req_t = axis_wide_req_t,
  parameter type axi_stream_out_rsp_t = axis_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i
);

  localparam int unsigned C_N      = dw_ratio(DataWidthIn, DataWidthOut);
  localparam int unsigned C_STRB_W = DataWidthIn / 8;
  // Zero-width side bands are carried as a single tied-off bit.
  localparam int unsigned C_ID_W   = (IdWidth   > 0) ? IdWidth   : 1;
  localparam int unsigned C_DEST_W = (DestWidth > 0) ? DestWidth : 1;
  localparam int unsigned C_USER_W = (UserWidth > 0) ? UserWidth : 1;
  localparam int unsigned C_LANE_W = DataWidthIn + 2 * C_STRB_W + C_USER_W;
  localparam int unsigned C_CNT_W  = $clog2(C_N);

`ifndef SYNTHESIS
  if (DataWidthIn % 8 != 0) begin : g_chk_in_bytes
    $error("DataWidthIn must be a multiple of 8");
  end
  if (DataWidthOut % DataWidthIn != 0) begin : g_chk_ratio
    $error("DataWidthOut must be an integer multiple of DataWidthIn");
  end
  if (C_N < 2) begin : g_chk_lanes
    $error("DataWidthOut/DataWidthIn must be at least 2");
  end
`endif

  dw_state_e            r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_last;
  logic [C_ID_W-1:0]    r_id;
  logic [C_DEST_W-1:0]  r_dest;

  logic                        w_in_valid;
  logic                        w_in_ready;
  logic                        w_in_hs;
  logic                        w_out_hs;
  logic                        w_route_chg;
  logic                        w_word_end;
  logic [C_CNT_W-1:0]          w_wr_lane;
  logic [C_LANE_W-1:0]         w_beat;
  logic [C_N*C_LANE_W-1:0]     w_buf;
  logic [DataWidthOut-1:0]     w_out_data;
  logic [C_N*C_STRB_W-1:0]     w_out_strb;
  logic [C_N*C_STRB_W-1:0]     w_out_keep;
  logic [C_N*C_USER_W-1:0]     w_out_user;

  assign w_in_valid = in_req_i.tvalid;
  assign w_beat     = {in_req_i.t.user, in_req_i.t.keep, in_req_i.t.strb, in_req_i.t.data};
  assign w_word_end = in_req_i.t.last || (r_cnt == C_CNT_W'(C_N - 1));
  assign w_out_hs   = (r_state == DW_FULL) && out_rsp_i.tready;
  assign w_in_hs    = w_in_valid && w_in_ready;
  // While a word is pending the new beat always opens lane 0.
  assign w_wr_lane  = (r_state == DW_FULL) ? '0 : r_cnt;

  // Route change looks only at the payload so tready never depends on tvalid.
  always_comb begin
    w_route_chg = 1'b0;
    if (FlushOnRouteChange && (r_cnt != '0)) begin
      w_route_chg = ((IdWidth   > 0) && (in_req_i.t.id   != r_id)) ||
                    ((DestWidth > 0) && (in_req_i.t.dest != r_dest));
    end
  end

  // Narrow-side ready: open while filling, follows the wide side while a word waits.
  always_comb begin
    w_in_ready = 1'b1;
    case (r_state)
      DW_FILL: w_in_ready = !w_route_chg;
      DW_FULL: w_in_ready = out_rsp_i.tready;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Fill/Full sequencing with lane counter and latched word attributes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= DW_FILL;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_dest  <= '0;
    end else begin
      case (r_state)
        DW_FILL: begin
          if (w_in_hs) begin
            r_last <= in_req_i.t.last;
            r_id   <= in_req_i.t.id;
            r_dest <= in_req_i.t.dest;
            if (w_word_end) begin
              r_state <= DW_FULL;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_in_valid && w_route_chg) begin
            r_state <= DW_FULL;
            r_cnt   <= '0;
            r_last  <= 1'b0;
          end
        end
        DW_FULL: begin
          if (w_out_hs) begin
            if (w_in_valid) begin
              r_last <= in_req_i.t.last;
              r_id   <= in_req_i.t.id;
              r_dest <= in_req_i.t.dest;
              if (in_req_i.t.last) begin
                r_state <= DW_FULL;
                r_cnt   <= '0;
              end else begin
                r_state <= DW_FILL;
                r_cnt   <= C_CNT_W'(1);
              end
            end else begin
              r_state <= DW_FILL;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= DW_FILL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  axi_stream_dw_lane_buf #(
    .LaneWidth (C_LANE_W),
    .NumLanes  (C_N)
  ) u_lane_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (w_out_hs),
    .wr_en_i   (w_in_hs),
    .wr_lane_i (w_wr_lane),
    .wr_data_i (w_beat),
    .buf_o     (w_buf)
  );

  for (genvar k = 0; k < C_N; k++) begin : g_unpack
    assign w_out_data[k*DataWidthIn +: DataWidthIn] = w_buf[k*C_LANE_W +: DataWidthIn];
    assign w_out_strb[k*C_STRB_W +: C_STRB_W]       = w_buf[k*C_LANE_W + DataWidthIn +: C_STRB_W];
    assign w_out_keep[k*C_STRB_W +: C_STRB_W]       = w_buf[k*C_LANE_W + DataWidthIn + C_STRB_W +: C_STRB_W];
    assign w_out_user[k*C_USER_W +: C_USER_W]       = w_buf[k*C_LANE_W + DataWidthIn + 2*C_STRB_W +: C_USER_W];
  end

  // Port structs assembled from the buffer and latched attributes.
  always_comb begin
    in_rsp_o          = '0;
    in_rsp_o.tready   = w_in_ready;
    out_req_o         = '0;
    out_req_o.tvalid  = (r_state == DW_FULL);
    out_req_o.t.data  = w_out_data;
    out_req_o.t.strb  = w_out_strb;
    out_req_o.t.keep  = w_out_keep;
    out_req_o.t.last  = r_last;
    out_req_o.t.id    = r_id;
    out_req_o.t.dest  = r_dest;
    out_req_o.t.user  = w_out_user;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_dw_upsizer_flex.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_axi_stream_dw_upsizer_flex                                 |
// | Brief  : Self-checking bench for the 8->32 upsizer with 2-bit id/dest  |
// |          and 1-bit user: word-level model plus directed literals.      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_axi_stream_dw_upsizer_flex;

  localparam int unsigned C_N = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [1:0] id;
    logic [1:0] dest;
    logic [0:0] user;
  } in_t;
  typedef struct packed { in_t t; logic tvalid; } in_req_t;
  typedef struct packed { logic tready; } rsp_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic [1:0]  dest;
    logic [3:0]  user;
  } out_t;
  typedef struct packed { out_t t; logic tvalid; } out_req_t;

  logic     clk_i;
  logic     rst_ni;
  in_req_t  in_req;
  rsp_t     in_rsp;
  out_req_t out_req;
  rsp_t     out_rsp;

  int n_vec    = 0;
  int n_err    = 0;
  int n_out_hs = 0;
  int cyc      = 0;

  in_t  pend[$];
  out_t expq[$];

  axi_stream_dw_upsizer_flex #(
    .DataWidthIn          (8),
    .DataWidthOut         (32),
    .IdWidth              (2),
    .DestWidth            (2),
    .UserWidth            (1),
    .FlushOnRouteChange   (1'b1),
    .axi_stream_in_req_t  (in_req_t),
    .axi_stream_in_rsp_t  (rsp_t),
    .axi_stream_out_req_t (out_req_t),
    .axi_stream_out_rsp_t (rsp_t)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_req_i  (in_req),
    .in_rsp_o  (in_rsp),
    .out_req_o (out_req),
    .out_rsp_i (out_rsp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Expected wide word from the beats collected so far: beat k in lane k, rest zero.
  function automatic out_t mk_word(input logic l);
    out_t w;
    w = '0;
    for (int k = 0; k < pend.size(); k++) begin
      w.data[k*8 +: 8] = pend[k].data;
      w.strb[k]        = pend[k].strb[0];
      w.keep[k]        = pend[k].keep[0];
      w.user[k]        = pend[k].user[0];
    end
    w.last = l;
    w.id   = pend[pend.size()-1].id;
    w.dest = pend[pend.size()-1].dest;
    return w;
  endfunction

  // Word-level reference and per-cycle compare.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pend.delete();
      expq.delete();
      chk("rst_tvalid", 64'(out_req.tvalid), 64'(0));
    end else begin
      chk("tvalid", 64'(out_req.tvalid), 64'(expq.size() != 0));
      if (out_req.tvalid && out_rsp.tready) begin
        n_out_hs++;
        if (expq.size() != 0) begin
          chk("word", 64'(out_req.t), 64'(expq[0]));
          void'(expq.pop_front());
        end
      end
      if (in_req.tvalid) begin
        if (pend.size() != 0 &&
            (in_req.t.id != pend[0].id || in_req.t.dest != pend[0].dest)) begin
          expq.push_back(mk_word(1'b0));
          pend.delete();
        end
        if (in_rsp.tready) begin
          pend.push_back(in_req.t);
          if (pend.size() == C_N || in_req.t.last) begin
            expq.push_back(mk_word(in_req.t.last));
            pend.delete();
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic l, input logic [1:0] id, input logic u);
    in_req.t.data = d;
    in_req.t.strb = 1'b1;
    in_req.t.keep = 1'b1;
    in_req.t.last = l;
    in_req.t.id   = id;
    in_req.t.dest = 2'd0;
    in_req.t.user = u;
    in_req.tvalid = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] id, input logic u);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    drive(d, l, id, u);
    while (!ok && guard < 64) begin
      @(negedge clk_i);
      ok = in_rsp.tready;
      next_cycle();
      guard++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: beat 0x%0h got tready 0, required 1", d);
    end
    in_req.tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int h0;
    rst_ni  = 1'b0;
    in_req  = '0;
    out_rsp = '0;
    repeat (3) next_cycle();
    @(negedge clk_i);
    chk("reset_tvalid", 64'(out_req.tvalid), 64'(0));
    chk("reset_payload", 64'(out_req.t), 64'(0));
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", 64'(in_rsp.tready), 64'(1));
    next_cycle();
    out_rsp.tready = 1'b1;

    // Full word, one cycle after the last byte.
    send(8'h11, 1'b0, 2'd0, 1'b0);
    send(8'h22, 1'b0, 2'd0, 1'b0);
    send(8'h33, 1'b0, 2'd0, 1'b0);
    send(8'h44, 1'b1, 2'd0, 1'b0);
    @(negedge clk_i);
    chk("full_tvalid", 64'(out_req.tvalid), 64'(1));
    chk("full_data", 64'(out_req.t.data), 64'h44332211);
    chk("full_keep", 64'(out_req.t.keep), 64'hF);
    chk("full_last", 64'(out_req.t.last), 64'(1));
    next_cycle();

    // Short packet, upper lanes zero.
    send(8'hAA, 1'b0, 2'd0, 1'b1);
    send(8'hBB, 1'b1, 2'd0, 1'b0);
    @(negedge clk_i);
    chk("short_data", 64'(out_req.t.data), 64'h0000BBAA);
    chk("short_keep", 64'(out_req.t.keep), 64'h3);
    chk("short_strb", 64'(out_req.t.strb), 64'h3);
    chk("short_user", 64'(out_req.t.user), 64'h1);
    chk("short_last", 64'(out_req.t.last), 64'(1));
    next_cycle();

    // Backpressure: word held, narrow side stalled, then released.
    out_rsp.tready = 1'b0;
    send(8'h55, 1'b0, 2'd0, 1'b0);
    send(8'h66, 1'b0, 2'd0, 1'b0);
    send(8'h77, 1'b0, 2'd0, 1'b0);
    send(8'h88, 1'b0, 2'd0, 1'b0);
    drive(8'h99, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_tvalid", 64'(out_req.tvalid), 64'(1));
      chk("bp_data", 64'(out_req.t.data), 64'h88776655);
      chk("bp_in_ready", 64'(in_rsp.tready), 64'(0));
      next_cycle();
    end
    out_rsp.tready = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 64'(in_rsp.tready), 64'(1));
    next_cycle();
    in_req.tvalid = 1'b0;
    send(8'hAA, 1'b0, 2'd0, 1'b0);
    send(8'hBB, 1'b0, 2'd0, 1'b0);
    send(8'hCC, 1'b1, 2'd0, 1'b0);
    @(negedge clk_i);
    chk("bp_next_word", 64'(out_req.t.data), 64'hCCBBAA99);
    next_cycle();

    // Route change closes a partial word.
    send(8'h01, 1'b0, 2'd1, 1'b0);
    send(8'h02, 1'b0, 2'd1, 1'b0);
    drive(8'h03, 1'b0, 2'd2, 1'b0);
    @(negedge clk_i);
    chk("route_stall", 64'(in_rsp.tready), 64'(0));
    next_cycle();
    @(negedge clk_i);
    chk("route_tvalid", 64'(out_req.tvalid), 64'(1));
    chk("route_data", 64'(out_req.t.data), 64'h00000201);
    chk("route_keep", 64'(out_req.t.keep), 64'h3);
    chk("route_last", 64'(out_req.t.last), 64'(0));
    chk("route_id", 64'(out_req.t.id), 64'(1));
    next_cycle();
    in_req.tvalid = 1'b0;
    send(8'h04, 1'b1, 2'd2, 1'b0);
    @(negedge clk_i);
    chk("route_new_data", 64'(out_req.t.data), 64'h00000403);
    chk("route_new_id", 64'(out_req.t.id), 64'(2));
    next_cycle();

    // Single-beat tlast word accepted while the previous word leaves.
    send(8'h10, 1'b0, 2'd0, 1'b0);
    send(8'h20, 1'b0, 2'd0, 1'b0);
    send(8'h30, 1'b0, 2'd0, 1'b0);
    send(8'h40, 1'b0, 2'd0, 1'b0);
    send(8'h50, 1'b1, 2'd0, 1'b0);
    @(negedge clk_i);
    chk("one_beat_data", 64'(out_req.t.data), 64'h00000050);
    chk("one_beat_keep", 64'(out_req.t.keep), 64'h1);
    chk("one_beat_last", 64'(out_req.t.last), 64'(1));
    next_cycle();

    // Streaming at one narrow beat per cycle.
    c0 = cyc;
    h0 = n_out_hs;
    for (int i = 0; i < 64; i++) begin
      send(8'($urandom), 1'b0, 2'd3, 1'($urandom));
    end
    chk("stream_cycles", 64'(cyc - c0), 64'(64));
    repeat (2) next_cycle();
    chk("stream_words", 64'(n_out_hs - h0), 64'(16));

    // Reset while a word is pending.
    out_rsp.tready = 1'b0;
    send(8'hA1, 1'b0, 2'd0, 1'b0);
    send(8'hA2, 1'b0, 2'd0, 1'b0);
    send(8'hA3, 1'b0, 2'd0, 1'b0);
    send(8'hA4, 1'b0, 2'd0, 1'b0);
    chk("pend_tvalid", 64'(out_req.tvalid), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("rst_async_tvalid", 64'(out_req.tvalid), 64'(0));
    next_cycle();
    rst_ni = 1'b1;
    out_rsp.tready = 1'b1;
    next_cycle();

    // Reset after two beats of a word.
    send(8'h12, 1'b0, 2'd0, 1'b0);
    send(8'h34, 1'b0, 2'd0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(out_req.tvalid), 64'(0));
    chk("rst_mid_data", 64'(out_req.t.data), 64'(0));
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_ready", 64'(in_rsp.tready), 64'(1));
    next_cycle();
    send(8'h0A, 1'b0, 2'd0, 1'b0);
    send(8'h0B, 1'b0, 2'd0, 1'b0);
    send(8'h0C, 1'b0, 2'd0, 1'b0);
    send(8'h0D, 1'b1, 2'd0, 1'b0);
    @(negedge clk_i);
    chk("rst_next_data", 64'(out_req.t.data), 64'h0D0C0B0A);
    chk("rst_next_keep", 64'(out_req.t.keep), 64'hF);
    next_cycle();

    repeat (3) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
